fifo_uart_tx: RTL
=================

Name: fifo_uart_tx

Overview:
Read-side consumer for the FIFO. Runs on the FIFO read clock. Pops one DATA_WIDTH word whenever the FIFO is non-empty. Serialises each word as a UART-style frame on a single pin: start bit, data LSB first, optional parity, stop bit. Provides a one-pin debug and streaming output for the TT tile.

Parameters:
DATA_WIDTH, 4, width of the FIFO read word and the number of data bits per frame
CLKS_PER_BIT, 8, clk cycles per serial bit; legal range 2..255
RD_LATENCY, 1, cycles from the rinc pulse until rdata is valid; legal values 0 or 1

Ports:
clk  input  1  block clock; this is the FIFO read clock
rst_n  input  1  asynchronous, active-low reset
en  input  1  allows a new frame to start; sampled only in IDLE
empty  input  1  FIFO empty flag, already synchronous to clk
rdata  input  DATA_WIDTH  FIFO read data
rinc  output  1  one-cycle pop strobe to the FIFO
tx  output  1  serial line; idles high
busy  output  1  high from the rinc cycle through the last stop-bit cycle
frame_done  output  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Reset (async, rst_n=0):
  - tx=1, rinc=0, busy=0, frame_done=0.
  - State=IDLE; bit counter and baud counter cleared.
  - Assertion mid-frame aborts the frame immediately; tx returns high with no glitch low.
- State machine: IDLE -> POP -> WAIT -> START -> DATA -> (PARITY) -> STOP -> IDLE.
- IDLE:
  - If en=1 and empty=0, assert rinc for exactly one cycle (cycle t) and go to POP.
  - Otherwise stay in IDLE with tx=1.
- POP/WAIT:
  - Latch rdata into a shift register at cycle t+RD_LATENCY.
  - With RD_LATENCY=0, latch at t and skip WAIT.
- START: tx=0 for CLKS_PER_BIT cycles. tx first goes low on the cycle after the latch.
- DATA:
  - Shift out bit 0 first. Each bit is held for CLKS_PER_BIT cycles.
  - A bit counter counts 0..DATA_WIDTH-1.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - frame_done=1 on the final cycle of STOP; then go to IDLE.
- Frame length: (2+DATA_WIDTH[+1 with parity])*CLKS_PER_BIT cycles, measured from the start bit.
- Back-to-back frames:
  - The earliest next rinc is the cycle after frame_done.
  - This gives a minimum idle gap of 1+RD_LATENCY cycles at tx=1 between frames.
- rinc is never asserted while empty=1 or while busy is already high. The block never issues a pop that causes underflow.
- Changes to empty or en during a frame are ignored; the frame always completes.
- Baud counter:
  - Width is ceil(log2(CLKS_PER_BIT)).
  - Counts 0..CLKS_PER_BIT-1 and then wraps.
  - The state or bit advances on the wrap.
- busy=1 from cycle t through the frame_done cycle, inclusive.

Optional Feature:
Macro: FIFO_UART_TX_PARITY_EN
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx carries even parity (XOR of the latched word) for CLKS_PER_BIT cycles.
  - Frame length becomes (3+DATA_WIDTH)*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic. DATA goes directly to STOP.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n=0 for 3 cycles, release; empty=1, en=1 for 50 cycles.
  - Response: tx=1, rinc=0, busy=0, frame_done=0 throughout.
- Single word (CLKS_PER_BIT=4, RD_LATENCY=1, no parity):
  - Stimulus: rdata=0xA, empty falls.
  - Response: one rinc pulse. tx pattern, 4 cycles each: 0 (start), 0,1,0,1, 1 (stop).
  - Response: tx falls 2 cycles after rinc; frame_done fires 24 cycles after tx falls (minus 1); busy covers rinc through frame_done.
- Back-to-back:
  - Stimulus: the FIFO holds 0x3 then 0xC.
  - Response: the second rinc occurs exactly 1 cycle after the first frame_done.
  - Response: tx is high for exactly 2 cycles between the first stop bit and the second start bit.
  - Response: the second data bits are 0,0,1,1.
- en gating:
  - Stimulus: en=0 with empty=0.
  - Response: no rinc.
  - Stimulus: drop en mid-frame.
  - Response: the current frame completes unchanged, and no new rinc follows while en=0.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 during the DATA bit 2 of word 0x5.
  - Response: tx=1 and busy=0 asynchronously.
  - Response: after release with empty=0, a new frame starts cleanly with a single rinc.
- Parity (FIFO_UART_TX_PARITY_EN defined):
  - Stimulus: word 0x7.
  - Response: the parity bit is 1 and the frame is 28 cycles at CLKS_PER_BIT=4.
  - Stimulus: word 0x5.
  - Response: the parity bit is 0.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side / serial-line bundle for fifo_uart_tx.
// The slave modport is the serialiser; the master modport is the FIFO/observer side.
interface fifo_uart_tx_if #(
  parameter int unsigned DATA_WIDTH = 4
);
  logic                  en;
  logic                  empty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rinc;
  logic                  tx;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output en, empty, rdata,
    input  rinc, tx, busy, frame_done
  );

  modport slave (
    input  en, empty, rdata,
    output rinc, tx, busy, frame_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer: pops one word per frame and sends it as a UART frame, LSB first.
// Optional even-parity bit between data and stop when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
  parameter int unsigned DATA_WIDTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned RD_LATENCY   = 1
) (
  input logic          clk,
  input logic          rst_n,
  fifo_uart_tx_if.slave bus
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PEN  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_POP    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif
  localparam logic [2:0] S_STOP   = 3'd6;

  logic [2:0]            r_state, w_state_nxt;
  logic [BAUD_W-1:0]     r_baud, w_baud_nxt;
  logic [BIT_W-1:0]      r_bit, w_bit_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                  r_tx, w_tx_nxt;
  logic                  r_rinc, w_rinc_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  w_wrap;
  logic                  w_start_ok;
  logic                  w_latch;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  r_parity, w_parity_nxt;
`endif

  assign w_wrap     = (r_baud == BAUD_LAST);
  assign w_start_ok = bus.en && !bus.empty;
  // With zero read latency the word is already valid in the pop cycle, so WAIT is skipped.
  assign w_latch    = (r_state == S_WAIT) || ((r_state == S_POP) && (RD_LATENCY == 0));

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_rinc_nxt  = 1'b0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    w_parity_nxt = r_parity;
`endif

    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_start_ok) begin
          w_state_nxt = S_POP;
          w_rinc_nxt  = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end

      S_POP, S_WAIT: begin
        if (w_latch) begin
          w_shift_nxt = bus.rdata;
`ifdef FIFO_UART_TX_PARITY_EN
          w_parity_nxt = ^bus.rdata;
`endif
          w_baud_nxt  = '0;
          w_tx_nxt    = 1'b0;
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end

      S_START: begin
        if (w_wrap) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end

      S_DATA: begin
        if (w_wrap) begin
          w_baud_nxt = '0;
          if (r_bit == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
            w_tx_nxt    = r_parity;
            w_state_nxt = S_PARITY;
`else
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt   = r_bit + BIT_W'(1);
            w_shift_nxt = r_shift >> 1;
            w_tx_nxt    = w_shift_nxt[0];
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end

`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_wrap) begin
          w_baud_nxt  = '0;
          w_tx_nxt    = 1'b1;
          w_state_nxt = S_STOP;
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
`endif

      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (r_baud == BAUD_PEN) begin
          w_done_nxt = 1'b1;
        end
        // A waiting word is popped right after frame_done to keep the idle gap minimal.
        if (w_wrap) begin
          w_baud_nxt = '0;
          if (w_start_ok) begin
            w_state_nxt = S_POP;
            w_rinc_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_rinc   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_baud   <= w_baud_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_tx     <= w_tx_nxt;
      r_rinc   <= w_rinc_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
`ifdef FIFO_UART_TX_PARITY_EN
      r_parity <= w_parity_nxt;
`endif
    end
  end

  assign bus.tx         = r_tx;
  assign bus.rinc       = r_rinc;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;

endmodule
